// File: rtl/core_avl_arbiter_pkg.sv
// ============================================================================
// core_avl_arbiter_pkg : master IDs and tag-entry sizing for the AVL arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package core_avl_arbiter_pkg;

    localparam logic AVL_ID_IFU = 1'b0;
    localparam logic AVL_ID_LSU = 1'b1;

    // A tag entry is {master id, burst length}.
    function automatic int tag_width(input int burst_w);
        return 1 + burst_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_avl_arbiter_fifo.sv
// ============================================================================
// core_avl_arbiter_fifo : synchronous tag FIFO with head always visible
// Revision: 1.0
// ============================================================================
`default_nettype none

module core_avl_arbiter_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/core_avl_arbiter.sv
// ============================================================================
// core_avl_arbiter : round-robin 2:1 Avalon arbiter with write-burst lock
//                    and in-order read-return routing
// Revision: 1.0
// ============================================================================
`default_nettype none

module core_avl_arbiter
    import core_avl_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int BURST_W         = 8
) (
    input  logic               clk,
    input  logic               rest,
    input  logic [31:0]        m0_address,
    input  logic               m0_read,
    input  logic               m0_write,
    input  logic [3:0]         m0_byte_en,
    input  logic [31:0]        m0_write_data,
    input  logic               m0_begin_burst_transfer,
    input  logic [BURST_W-1:0] m0_burst_count,
    output logic               m0_request_ready,
    output logic [31:0]        m0_read_data,
    output logic               m0_read_data_valid,
    input  logic [31:0]        m1_address,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [3:0]         m1_byte_en,
    input  logic [31:0]        m1_write_data,
    input  logic               m1_begin_burst_transfer,
    input  logic [BURST_W-1:0] m1_burst_count,
    output logic               m1_request_ready,
    output logic [31:0]        m1_read_data,
    output logic               m1_read_data_valid,
    output logic [31:0]        s_address,
    output logic               s_read,
    output logic               s_write,
    output logic [3:0]         s_byte_en,
    output logic [31:0]        s_write_data,
    output logic               s_begin_burst_transfer,
    output logic [BURST_W-1:0] s_burst_count,
    input  logic               s_request_ready,
    input  logic [31:0]        s_read_data,
    input  logic               s_read_data_valid,
    output logic               err_spurious
);

    localparam int TAG_W = tag_width(BURST_W);

    logic               wlock;
    logic               owner;
    logic               last_grant;
    logic [BURST_W-1:0] wbeats;
    logic [BURST_W-1:0] beats_done;

    logic               req0;
    logic               req1;
    logic               gv;
    logic               gid;
    logic               g_read;
    logic               g_write;
    logic               g_begin;
    logic [BURST_W-1:0] g_bc;
    logic               acc;

    logic               push;
    logic               pop;
    logic [TAG_W-1:0]   push_data;
    logic [TAG_W-1:0]   head;
    logic               tag_empty;
    logic               tag_full;
    logic               head_id;
    logic [BURST_W-1:0] head_bc;
    logic               beat;
    logic               last_beat;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_comb begin
        gv  = 1'b0;
        gid = AVL_ID_IFU;
        if (wlock) begin
            gv  = 1'b1;
            gid = owner;
        end else if (req0 && req1) begin
            gv  = 1'b1;
            gid = ~last_grant;
        end else if (req0) begin
            gv  = 1'b1;
            gid = AVL_ID_IFU;
        end else if (req1) begin
            gv  = 1'b1;
            gid = AVL_ID_LSU;
        end
    end

    assign g_read  = gid ? m1_read                 : m0_read;
    assign g_write = gid ? m1_write                : m0_write;
    assign g_begin = gid ? m1_begin_burst_transfer : m0_begin_burst_transfer;
    assign g_bc    = gid ? m1_burst_count          : m0_burst_count;

    // A read with no free tag is hidden from the slave entirely.
    assign acc = s_request_ready & gv & (g_read | g_write) & ~(g_read & tag_full);

    always_comb begin
        s_address              = '0;
        s_read                 = 1'b0;
        s_write                = 1'b0;
        s_byte_en              = '0;
        s_write_data           = '0;
        s_begin_burst_transfer = 1'b0;
        s_burst_count          = '0;
        if (gv) begin
            s_address              = gid ? m1_address    : m0_address;
            s_read                 = g_read & ~tag_full;
            s_write                = g_write;
            s_byte_en              = gid ? m1_byte_en    : m0_byte_en;
            s_write_data           = gid ? m1_write_data : m0_write_data;
            s_begin_burst_transfer = g_begin;
            s_burst_count          = g_bc;
        end
    end

    assign m0_request_ready = acc & (gid == AVL_ID_IFU);
    assign m1_request_ready = acc & (gid == AVL_ID_LSU);

    assign push      = acc & g_read;
    assign push_data = {gid, (g_bc == '0) ? BURST_W'(1) : g_bc};
    assign head_id   = head[TAG_W-1];
    assign head_bc   = head[BURST_W-1:0];

    assign beat      = s_read_data_valid & ~tag_empty;
    assign last_beat = beat & ((beats_done + BURST_W'(1)) == head_bc);
    assign pop       = last_beat;

    assign m0_read_data       = s_read_data;
    assign m1_read_data       = s_read_data;
    assign m0_read_data_valid = beat & (head_id == AVL_ID_IFU);
    assign m1_read_data_valid = beat & (head_id == AVL_ID_LSU);

    core_avl_arbiter_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rest      (rest),
        .flush     (1'b0),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            wlock        <= 1'b0;
            owner        <= AVL_ID_IFU;
            wbeats       <= '0;
            last_grant   <= AVL_ID_LSU;
            beats_done   <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (acc && g_read) begin
                last_grant <= gid;
            end
            if (acc && g_write) begin
                if (wlock) begin
                    wbeats <= wbeats - BURST_W'(1);
                    if (wbeats == BURST_W'(1)) begin
                        wlock      <= 1'b0;
                        last_grant <= owner;
                    end
                end else if (g_begin && (g_bc > BURST_W'(1))) begin
                    wlock  <= 1'b1;
                    owner  <= gid;
                    wbeats <= g_bc - BURST_W'(1);
                end else begin
                    last_grant <= gid;
                end
            end
            if (beat) begin
                beats_done <= last_beat ? '0 : beats_done + BURST_W'(1);
            end
            if (s_read_data_valid && tag_empty) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_core_avl_arbiter.sv
// ============================================================================
// tb_core_avl_arbiter : directed vector table plus hand-written corner sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_core_avl_arbiter;

    logic        clk = 1'b0;
    logic        rest;
    logic [31:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_byte_en, m1_byte_en;
    logic [31:0] m0_write_data, m1_write_data;
    logic        m0_begin_burst_transfer, m1_begin_burst_transfer;
    logic [7:0]  m0_burst_count, m1_burst_count;
    logic        m0_request_ready, m1_request_ready;
    logic [31:0] m0_read_data, m1_read_data;
    logic        m0_read_data_valid, m1_read_data_valid;
    logic [31:0] s_address;
    logic        s_read, s_write;
    logic [3:0]  s_byte_en;
    logic [31:0] s_write_data;
    logic        s_begin_burst_transfer;
    logic [7:0]  s_burst_count;
    logic        s_request_ready;
    logic [31:0] s_read_data;
    logic        s_read_data_valid;
    logic        err_spurious;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    core_avl_arbiter #(.MAX_OUTSTANDING(4), .BURST_W(8)) dut (
        .clk                     (clk),
        .rest                    (rest),
        .m0_address              (m0_address),
        .m0_read                 (m0_read),
        .m0_write                (m0_write),
        .m0_byte_en              (m0_byte_en),
        .m0_write_data           (m0_write_data),
        .m0_begin_burst_transfer (m0_begin_burst_transfer),
        .m0_burst_count          (m0_burst_count),
        .m0_request_ready        (m0_request_ready),
        .m0_read_data            (m0_read_data),
        .m0_read_data_valid      (m0_read_data_valid),
        .m1_address              (m1_address),
        .m1_read                 (m1_read),
        .m1_write                (m1_write),
        .m1_byte_en              (m1_byte_en),
        .m1_write_data           (m1_write_data),
        .m1_begin_burst_transfer (m1_begin_burst_transfer),
        .m1_burst_count          (m1_burst_count),
        .m1_request_ready        (m1_request_ready),
        .m1_read_data            (m1_read_data),
        .m1_read_data_valid      (m1_read_data_valid),
        .s_address               (s_address),
        .s_read                  (s_read),
        .s_write                 (s_write),
        .s_byte_en               (s_byte_en),
        .s_write_data            (s_write_data),
        .s_begin_burst_transfer  (s_begin_burst_transfer),
        .s_burst_count           (s_burst_count),
        .s_request_ready         (s_request_ready),
        .s_read_data             (s_read_data),
        .s_read_data_valid       (s_read_data_valid),
        .err_spurious            (err_spurious)
    );

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0;
        logic [7:0]  bc0;
        logic        r1, w1;
        logic [31:0] a1;
        logic [7:0]  bc1;
        logic        srdy, srdv;
        logic [31:0] sd;
        logic        e_sread, e_swrite;
        logic [31:0] e_saddr;
        logic        e_rr0, e_rr1, e_rdv0, e_rdv1, e_err;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(
        input logic r0, input logic w0, input logic [31:0] a0, input logic [7:0] bc0,
        input logic r1, input logic w1, input logic [31:0] a1, input logic [7:0] bc1,
        input logic srdy, input logic srdv, input logic [31:0] sd,
        input logic es_r, input logic es_w, input logic [31:0] es_a,
        input logic rr0, input logic rr1, input logic rdv0, input logic rdv1, input logic err);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.bc0 = bc0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.bc1 = bc1;
        v.srdy = srdy; v.srdv = srdv; v.sd = sd;
        v.e_sread = es_r; v.e_swrite = es_w; v.e_saddr = es_a;
        v.e_rr0 = rr0; v.e_rr1 = rr1; v.e_rdv0 = rdv0; v.e_rdv1 = rdv1; v.e_err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives both masters and the slave response for one cycle, then settles.
    task automatic drv(
        input logic r0, input logic w0, input logic [31:0] a0, input logic b0, input logic [7:0] bc0,
        input logic r1, input logic w1, input logic [31:0] a1, input logic b1, input logic [7:0] bc1,
        input logic srdy, input logic srdv, input logic [31:0] sd);
        m0_read = r0; m0_write = w0; m0_address = a0; m0_write_data = a0 ^ 32'hA5A5_0000;
        m0_begin_burst_transfer = b0; m0_burst_count = bc0;
        m1_read = r1; m1_write = w1; m1_address = a1; m1_write_data = a1 ^ 32'h5A5A_0000;
        m1_begin_burst_transfer = b1; m1_burst_count = bc1;
        s_request_ready = srdy; s_read_data_valid = srdv; s_read_data = sd;
        #2;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rest = 1'b0;
        m0_byte_en = 4'h3;
        m1_byte_en = 4'hC;
        idle();
        repeat (2) cyc();
        rest = 1'b1;

        //           m0: r w addr   bc  m1: r w addr   bc  rdy vld data      exp: rd wr addr    rr0 rr1 v0 v1 err
        vecs[0]  = mk(0,0,32'h0,  0,   0,0,32'h0,  0,   0,0,32'h0,        0,0,32'h0,   0,0,0,0,0);
        vecs[1]  = mk(1,0,32'h100,1,   1,0,32'h200,1,   1,0,32'h0,        1,0,32'h100, 1,0,0,0,0);
        vecs[2]  = mk(0,0,32'h0,  0,   1,0,32'h200,1,   1,0,32'h0,        1,0,32'h200, 0,1,0,0,0);
        vecs[3]  = mk(0,0,32'h0,  0,   0,0,32'h0,  0,   0,1,32'hD0D0_0000,0,0,32'h0,   0,0,1,0,0);
        vecs[4]  = mk(0,0,32'h0,  0,   0,0,32'h0,  0,   0,1,32'hD1D1_1111,0,0,32'h0,   0,0,0,1,0);
        vecs[5]  = mk(0,0,32'h0,  0,   0,0,32'h0,  0,   0,1,32'hBAD0_0000,0,0,32'h0,   0,0,0,0,0);
        vecs[6]  = mk(0,0,32'h0,  0,   0,0,32'h0,  0,   0,0,32'h0,        0,0,32'h0,   0,0,0,0,1);
        vecs[7]  = mk(0,0,32'h0,  0,   1,0,32'h300,3,   1,0,32'h0,        1,0,32'h300, 0,1,0,0,1);
        vecs[8]  = mk(1,0,32'h400,1,   0,0,32'h0,  0,   1,0,32'h0,        1,0,32'h400, 1,0,0,0,1);
        vecs[9]  = mk(0,0,32'h0,  0,   0,0,32'h0,  0,   0,1,32'hB1,       0,0,32'h0,   0,0,0,1,1);
        vecs[10] = mk(0,0,32'h0,  0,   0,0,32'h0,  0,   0,1,32'hB2,       0,0,32'h0,   0,0,0,1,1);
        vecs[11] = mk(0,0,32'h0,  0,   0,0,32'h0,  0,   0,1,32'hB3,       0,0,32'h0,   0,0,0,1,1);
        vecs[12] = mk(0,0,32'h0,  0,   0,0,32'h0,  0,   0,1,32'hB4,       0,0,32'h0,   0,0,1,0,1);
        vecs[13] = mk(0,0,32'h0,  0,   0,0,32'h0,  0,   0,1,32'hB5,       0,0,32'h0,   0,0,0,0,1);
        vecs[14] = mk(1,0,32'h500,1,   1,0,32'h600,1,   0,0,32'h0,        1,0,32'h600, 0,0,0,0,1);
        vecs[15] = mk(1,0,32'h700,0,   1,0,32'h800,1,   1,0,32'h0,        1,0,32'h800, 0,1,0,0,1);
        vecs[16] = mk(1,0,32'h700,0,   0,0,32'h0,  0,   1,0,32'h0,        1,0,32'h700, 1,0,0,0,1);
        vecs[17] = mk(0,0,32'h0,  0,   0,0,32'h0,  0,   0,1,32'hC1,       0,0,32'h0,   0,0,0,1,1);
        vecs[18] = mk(0,0,32'h0,  0,   0,0,32'h0,  0,   0,1,32'hC2,       0,0,32'h0,   0,0,1,0,1);
        vecs[19] = mk(0,0,32'h0,  0,   0,0,32'h0,  0,   0,1,32'hC3,       0,0,32'h0,   0,0,0,0,1);

        for (int i = 0; i < 20; i++) begin
            drv(vecs[i].r0, vecs[i].w0, vecs[i].a0, 1'b1, vecs[i].bc0,
                vecs[i].r1, vecs[i].w1, vecs[i].a1, 1'b1, vecs[i].bc1,
                vecs[i].srdy, vecs[i].srdv, vecs[i].sd);
            chk($sformatf("v%0d s_read", i),       32'(s_read),             32'(vecs[i].e_sread));
            chk($sformatf("v%0d s_write", i),      32'(s_write),            32'(vecs[i].e_swrite));
            chk($sformatf("v%0d s_address", i),    s_address,               vecs[i].e_saddr);
            chk($sformatf("v%0d m0_ready", i),     32'(m0_request_ready),   32'(vecs[i].e_rr0));
            chk($sformatf("v%0d m1_ready", i),     32'(m1_request_ready),   32'(vecs[i].e_rr1));
            chk($sformatf("v%0d m0_rdv", i),       32'(m0_read_data_valid), 32'(vecs[i].e_rdv0));
            chk($sformatf("v%0d m1_rdv", i),       32'(m1_read_data_valid), 32'(vecs[i].e_rdv1));
            chk($sformatf("v%0d m0_rdata", i),     m0_read_data,            vecs[i].sd);
            chk($sformatf("v%0d err", i),          32'(err_spurious),       32'(vecs[i].e_err));
            cyc();
        end

        // Write burst lock: m1 owns the port for 4 beats, including a bubble.
        drv(0,0,32'h0,0,0,          0,1,32'h1000,1,4, 1,0,0);
        chk("wb0 s_write", 32'(s_write), 32'd1);
        chk("wb0 s_address", s_address, 32'h1000);
        chk("wb0 s_wdata", s_write_data, 32'h5A5A_1000);
        chk("wb0 s_bc", 32'(s_burst_count), 32'd4);
        chk("wb0 s_byte_en", 32'(s_byte_en), 32'hC);
        chk("wb0 m1_ready", 32'(m1_request_ready), 32'd1);
        cyc();
        drv(1,0,32'h2000,1,1,       0,1,32'h1004,0,4, 1,0,0);
        chk("wb1 s_address", s_address, 32'h1004);
        chk("wb1 s_read", 32'(s_read), 32'd0);
        chk("wb1 m0_ready", 32'(m0_request_ready), 32'd0);
        chk("wb1 m1_ready", 32'(m1_request_ready), 32'd1);
        cyc();
        drv(1,0,32'h2000,1,1,       0,0,32'h1008,0,4, 1,0,0);
        chk("wb_bubble s_address", s_address, 32'h1008);
        chk("wb_bubble s_read", 32'(s_read), 32'd0);
        chk("wb_bubble m0_ready", 32'(m0_request_ready), 32'd0);
        cyc();
        drv(1,0,32'h2000,1,1,       0,1,32'h1008,0,4, 1,0,0);
        chk("wb2 m0_ready", 32'(m0_request_ready), 32'd0);
        chk("wb2 m1_ready", 32'(m1_request_ready), 32'd1);
        cyc();
        drv(1,0,32'h2000,1,1,       0,1,32'h100C,0,4, 1,0,0);
        chk("wb3 s_wdata", s_write_data, 32'h5A5A_100C);
        chk("wb3 m0_ready", 32'(m0_request_ready), 32'd0);
        chk("wb3 m1_ready", 32'(m1_request_ready), 32'd1);
        cyc();
        drv(1,0,32'h2000,1,1,       0,1,32'h3000,1,1, 1,0,0);
        chk("wb_after s_address", s_address, 32'h2000);
        chk("wb_after s_read", 32'(s_read), 32'd1);
        chk("wb_after m0_ready", 32'(m0_request_ready), 32'd1);
        chk("wb_after m1_ready", 32'(m1_request_ready), 32'd0);
        cyc();
        drv(0,0,32'h0,0,0,          0,1,32'h3000,1,1, 1,1,32'hE0);
        chk("wb_single m1_ready", 32'(m1_request_ready), 32'd1);
        chk("wb_ret m0_rdv", 32'(m0_read_data_valid), 32'd1);
        cyc();

        // Tag FIFO full: the fifth read is held off until a beat returns.
        for (int i = 0; i < 4; i++) begin
            drv(1,0,32'h4000 + 32'(4*i),1,1, 0,0,0,0,0, 1,0,0);
            chk($sformatf("full%0d m0_ready", i), 32'(m0_request_ready), 32'd1);
            cyc();
        end
        drv(1,0,32'h4010,1,1, 0,0,0,0,0, 1,0,0);
        chk("full_blk s_read", 32'(s_read), 32'd0);
        chk("full_blk m0_ready", 32'(m0_request_ready), 32'd0);
        cyc();
        drv(1,0,32'h4010,1,1, 0,0,0,0,0, 1,1,32'hF0);
        chk("full_ret s_read", 32'(s_read), 32'd0);
        chk("full_ret m0_ready", 32'(m0_request_ready), 32'd0);
        chk("full_ret m0_rdv", 32'(m0_read_data_valid), 32'd1);
        cyc();
        drv(1,0,32'h4010,1,1, 0,0,0,0,0, 1,0,0);
        chk("full_acc s_read", 32'(s_read), 32'd1);
        chk("full_acc m0_ready", 32'(m0_request_ready), 32'd1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drv(0,0,0,0,0, 0,0,0,0,0, 0,1,32'hF1 + 32'(i));
            chk($sformatf("drain%0d m0_rdv", i), 32'(m0_read_data_valid), 32'd1);
            cyc();
        end
        drv(0,0,0,0,0, 0,0,0,0,0, 0,1,32'hFF);
        chk("drain_empty m0_rdv", 32'(m0_read_data_valid), 32'd0);
        chk("drain_empty m1_rdv", 32'(m1_read_data_valid), 32'd0);
        cyc();

        // Reset during a write lock with two m1 reads outstanding.
        drv(0,0,0,0,0, 1,0,32'h5000,1,1, 1,0,0);
        cyc();
        drv(0,0,0,0,0, 1,0,32'h5004,1,1, 1,0,0);
        cyc();
        drv(0,1,32'h6000,1,1, 0,0,0,0,0, 1,0,0);
        chk("pre_rst m0_ready", 32'(m0_request_ready), 32'd1);
        cyc();
        drv(0,0,0,0,0, 0,1,32'h7000,1,4, 1,0,0);
        chk("pre_rst lock m1_ready", 32'(m1_request_ready), 32'd1);
        cyc();
        drv(1,0,32'h8000,1,1, 0,0,0,0,0, 1,0,0);
        chk("pre_rst locked m0_ready", 32'(m0_request_ready), 32'd0);
        chk("pre_rst err", 32'(err_spurious), 32'd1);
        drv(0,0,0,0,0, 0,0,0,0,0, 0,1,32'h99);
        rest = 1'b0;
        #1;
        chk("rst err", 32'(err_spurious), 32'd0);
        chk("rst m1_rdv", 32'(m1_read_data_valid), 32'd0);
        chk("rst m0_rdv", 32'(m0_read_data_valid), 32'd0);
        chk("rst s_write", 32'(s_write), 32'd0);
        chk("rst s_address", s_address, 32'h0);
        cyc();
        rest = 1'b1;
        drv(1,0,32'h9000,1,1, 1,0,32'h9100,1,1, 1,0,0);
        chk("post_rst s_address", s_address, 32'h9000);
        chk("post_rst m0_ready", 32'(m0_request_ready), 32'd1);
        chk("post_rst m1_ready", 32'(m1_request_ready), 32'd0);
        cyc();
        idle();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
